// File: rtl/seg_scan_if.sv
// Bundle of data/control inputs and scan outputs for the 7-segment scanner.
// The master drives the value, enables and load strobe; the slave drives the pins.
interface seg_scan_if #(
  parameter int DIGITS = 8,
  parameter int AN_W   = 3
);
  logic [4*DIGITS-1:0] data_in;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   digit_en;
  logic                load;
  logic [AN_W-1:0]     an;
  logic [7:0]          seg;
  logic                frame_done;

  modport master (output data_in, dp_in, digit_en, load,
                  input  an, seg, frame_done);
  modport slave  (input  data_in, dp_in, digit_en, load,
                  output an, seg, frame_done);
endinterface

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment scanner with hex decode and a frame-boundary double buffer.
// an/seg update together once every SCAN_DIV cycles; frame_done pulses the cycle after wrap.
// No backpressure: load is a strobe, last load in a frame wins. Optional: SEG_LZ_BLANK_EN.
module seg_scan_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000,
  parameter int AN_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int              CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [AN_W-1:0] AN_MAX  = AN_W'(DIGITS - 1);

  logic [CW-1:0]       cnt;
  logic [AN_W-1:0]     an_q, an_nxt;
  logic [7:0]          seg_q, seg_nxt;
  logic                fd_q;
  logic                tick, wrap;
  logic [4*DIGITS-1:0] pend_dat, act_dat, act_dat_nxt;
  logic [DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
  logic [DIGITS-1:0]   lz_blank;
  logic [3:0]          nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick   = (cnt == CNT_MAX);
  assign wrap   = tick && (an_q == AN_MAX);
  assign an_nxt = (an_q == AN_MAX) ? '0 : an_q + AN_W'(1);

  // Value that will be active after this edge; a load coinciding with the wrap goes straight live.
  always_comb begin
    act_dat_nxt = act_dat;
    act_dp_nxt  = act_dp;
    if (wrap) begin
      if (bus.load) begin
        act_dat_nxt = bus.data_in;
        act_dp_nxt  = bus.dp_in;
      end else begin
        act_dat_nxt = pend_dat;
        act_dp_nxt  = pend_dp;
      end
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic zero_run;
  // Digit i blanks when it and every digit above it is zero or disabled; digit 0 never blanks.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run    = zero_run && (!bus.digit_en[i] || (act_dat_nxt[4*i +: 4] == 4'h0));
      lz_blank[i] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Segment pattern for the digit that becomes selected on the coming tick.
  always_comb begin
    nib     = act_dat_nxt[{an_nxt, 2'b00} +: 4];
    seg_nxt = {act_dp_nxt[an_nxt], hex7(nib)};
    if (lz_blank[an_nxt])       seg_nxt[6:0] = 7'h00;
    if (!bus.digit_en[an_nxt])  seg_nxt      = 8'h00;
  end

  // Prescaler, digit select and registered segment outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      an_q  <= '0;
      seg_q <= 8'h00;
      fd_q  <= 1'b0;
    end else begin
      cnt  <= tick ? '0 : cnt + CW'(1);
      fd_q <= wrap;
      if (tick) begin
        an_q  <= an_nxt;
        seg_q <= seg_nxt;
      end
    end
  end

  // Pending buffer takes every load; active buffer swaps only at the frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_dat <= '0;
      pend_dp  <= '0;
      act_dat  <= '0;
      act_dp   <= '0;
    end else begin
      if (bus.load) begin
        pend_dat <= bus.data_in;
        pend_dp  <= bus.dp_in;
      end
      act_dat <= act_dat_nxt;
      act_dp  <= act_dp_nxt;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: frame-level reference model checked every cycle,
// plus a vector table and hand sequences for load-at-wrap and mid-frame reset.
module tb_seg_scan_display;
  localparam int DG = 8;
  localparam int SD = 4;
  localparam int AW = 3;
  localparam int FRAME = SD * DG;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_scan_if #(.DIGITS(DG), .AN_W(AW)) bus ();
  seg_scan_display #(.DIGITS(DG), .SCAN_DIV(SD), .AN_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int k;                       // edges since reset release
  logic [31:0] m_pend_d, m_act_d;
  logic [7:0]  m_pend_p, m_act_p;
  logic [7:0]  exp_seg;
  logic        exp_fd;
  logic [6:0]  lut [16];

  typedef struct {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
    int          an;
    logic [7:0]  seg;
  } vec_t;
  vec_t tv [14];

  function automatic int exp_an();
    return (k / SD) % DG;
  endfunction

  function automatic logic [7:0] model_seg(input int a);
    logic [31:0] masked;
    logic [31:0] sh;
    logic [6:0]  s;
    if (!bus.digit_en[a]) return 8'h00;
    sh = m_act_d >> (4 * a);
    s = lut[sh[3:0]];
    masked = 32'h0;
    for (int j = 0; j < DG; j++)
      if (bus.digit_en[j]) masked = masked | (m_act_d & (32'hF << (4 * j)));
`ifdef SEG_LZ_BLANK_EN
    if (a > 0 && (masked >> (4 * a)) == 32'h0) s = 7'h00;
`endif
    return {m_act_p[a], s};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at k=%0d: got %0h want %0h", name, k, got, want);
    end
  endtask

  // Advance the model over the coming edge, then compare the DUT just after it.
  task automatic step();
    int   kn;
    logic tk, wr;
    kn = k + 1;
    tk = (kn % SD) == 0;
    wr = (kn % FRAME) == 0;
    if (wr) begin
      m_act_d = bus.load ? bus.data_in : m_pend_d;
      m_act_p = bus.load ? bus.dp_in   : m_pend_p;
    end
    if (bus.load) begin
      m_pend_d = bus.data_in;
      m_pend_p = bus.dp_in;
    end
    if (tk) exp_seg = model_seg((kn / SD) % DG);
    exp_fd = wr;
    k = kn;
    @(posedge clk);
    #1;
    check("an", 32'(bus.an), 32'(exp_an()));
    check("seg", 32'(bus.seg), 32'(exp_seg));
    check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_an", 32'(bus.an), 32'h0);
    check("rst_seg", 32'(bus.seg), 32'h0);
    check("rst_fd", 32'(bus.frame_done), 32'h0);
    k = 0;
    m_pend_d = '0; m_pend_p = '0; m_act_d = '0; m_act_p = '0;
    exp_seg = 8'h00; exp_fd = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_until_wrap();
    int c;
    c = 0;
    do begin
      step();
      c++;
    end while ((k % FRAME) != 0 && c < 2 * FRAME);
  endtask

  initial begin
    int fd_cnt;
    int c;
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    tv[0]  = '{32'h89AB_CDEF, 8'h01, 8'hFF, 0, 8'hF1};
    tv[1]  = '{32'h89AB_CDEF, 8'h01, 8'hFF, 3, 8'h39};
    tv[2]  = '{32'h89AB_CDEF, 8'h01, 8'hFF, 7, 8'h7F};
    tv[3]  = '{32'h1234_5678, 8'h00, 8'hF0, 0, 8'h00};
    tv[4]  = '{32'h1234_5678, 8'h00, 8'hF0, 3, 8'h00};
    tv[5]  = '{32'h1234_5678, 8'h00, 8'hF0, 4, 8'h66};
    tv[6]  = '{32'h0000_0A05, 8'h00, 8'hFF, 2, 8'h77};
    tv[7]  = '{32'h0000_0A05, 8'h00, 8'hFF, 1, 8'h3F};
    tv[8]  = '{32'h0000_0A05, 8'h00, 8'hFF, 0, 8'h6D};
    tv[9]  = '{32'h0000_0000, 8'h00, 8'hFF, 0, 8'h3F};
`ifdef SEG_LZ_BLANK_EN
    tv[10] = '{32'h0000_0A05, 8'h00, 8'hFF, 7, 8'h00};
    tv[11] = '{32'h0000_0A05, 8'h00, 8'hFF, 3, 8'h00};
    tv[12] = '{32'h0000_0000, 8'h00, 8'hFF, 1, 8'h00};
    tv[13] = '{32'h0000_0000, 8'h80, 8'hFF, 7, 8'h80};
`else
    tv[10] = '{32'h0000_0A05, 8'h00, 8'hFF, 7, 8'h3F};
    tv[11] = '{32'h0000_0A05, 8'h00, 8'hFF, 3, 8'h3F};
    tv[12] = '{32'h0000_0000, 8'h00, 8'hFF, 1, 8'h3F};
    tv[13] = '{32'h0000_0000, 8'h80, 8'hFF, 7, 8'hBF};
`endif

    bus.data_in = '0; bus.dp_in = '0; bus.digit_en = 8'hFF; bus.load = 1'b0;
    #2;
    do_reset();

    // Idle scan after reset: count frame_done pulses over two frames.
    fd_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.frame_done) fd_cnt++;
    end
    check("fd_pulses", 32'(fd_cnt), 32'd2);

    // Vector table: load mid-frame, then read the target digit in the next frame.
    for (int i = 0; i < 14; i++) begin
      for (int w = 0; w < 5 + i; w++) step();
      bus.data_in = tv[i].data; bus.dp_in = tv[i].dp; bus.digit_en = tv[i].en;
      bus.load = 1'b1;
      step();
      bus.load = 1'b0;
      run_until_wrap();
      c = 0;
      while (exp_an() != tv[i].an && c < FRAME) begin step(); c++; end
      check($sformatf("vec%0d_an", i), 32'(bus.an), 32'(tv[i].an));
      check($sformatf("vec%0d_seg", i), 32'(bus.seg), 32'(tv[i].seg));
    end

    // Load on the very edge of the wrapping tick: new digit 0 shows at once.
    bus.digit_en = 8'hFF;
    c = 0;
    while ((k % FRAME) != FRAME - 1 && c < 2 * FRAME) begin step(); c++; end
    bus.data_in = 32'h1111_1117; bus.dp_in = 8'h00; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("load_at_wrap", 32'(bus.seg), 32'h07);
    for (int i = 0; i < FRAME; i++) step();

    // Reset asserted mid-slot at digit 5, then scan resumes with full slots.
    c = 0;
    while (!(exp_an() == 5 && (k % SD) == 1) && c < 2 * FRAME) begin step(); c++; end
    do_reset();
    for (int i = 0; i < FRAME + 8; i++) step();

    // Random data, enables and sparse loads against the model.
    for (int i = 0; i < 800; i++) begin
      bus.data_in  = $urandom >> $urandom_range(0, 31);
      bus.dp_in    = 8'($urandom);
      bus.digit_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      bus.load     = ($urandom_range(0, 9) == 0);
      step();
    end
    bus.load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
